// File: rtl/efuse_macro_ctrl.sv
// eFuse macro timing engine: serialises bit-wise read and program
// windows with programmable setup, strobe and hold lengths.
module efuse_macro_ctrl #(
    parameter int NBITS = 32,
    parameter int AW    = 5,
    parameter int T_SU  = 2,
    parameter int T_RD  = 4,
    parameter int T_PGM = 10,
    parameter int T_HD  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             read,
    input  logic             write,
    input  logic             margin_read,
    input  logic [NBITS-1:0] data_write,
    output logic             rd_done,
    output logic             wr_done,
    output logic [NBITS-1:0] data_read,
    output logic             busy,
    output logic             efuse_cs,
    output logic [AW-1:0]    efuse_addr,
    output logic             efuse_strb,
    output logic             efuse_pgmen,
    output logic             efuse_mr,
    input  logic             efuse_dout
);

    localparam int T1   = (T_SU > T_RD) ? T_SU : T_RD;
    localparam int T2   = (T1 > T_PGM) ? T1 : T_PGM;
    localparam int TMAX = (T2 > T_HD) ? T2 : T_HD;
    localparam int CW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] SU_L  = CW'(T_SU - 1);
    localparam logic [CW-1:0] RD_L  = CW'(T_RD - 1);
    localparam logic [CW-1:0] PG_L  = CW'(T_PGM - 1);
    localparam logic [CW-1:0] HD_L  = CW'(T_HD - 1);
    localparam logic [AW-1:0] LAST  = AW'(NBITS - 1);

    typedef enum logic [3:0] {
        IDLE, RD_SU, RD_STB, RD_HD,
        PG_CHK, PG_SU, PG_STB, PG_HD, DONE
    } state_t;

    state_t           state, nxt_state;
    logic [CW-1:0]    cnt, nxt_cnt;
    logic [AW-1:0]    idx, nxt_idx;
    logic [NBITS-1:0] wdata;
    logic [NBITS-1:0] shadow;
    logic             rd_mode;
    logic             last_bit;

    assign last_bit = (idx == LAST);

    // Next state, window timer and bit index.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + 1'b1;
        nxt_idx   = idx;
        unique case (state)
            IDLE: begin
                nxt_cnt = '0;
                if (read) begin
                    nxt_state = RD_SU;
                    nxt_idx   = '0;
                end else if (write) begin
                    nxt_state = PG_CHK;
                    nxt_idx   = '0;
                end
            end
            RD_SU: if (cnt == SU_L) begin
                nxt_state = RD_STB;
                nxt_cnt   = '0;
            end
            RD_STB: if (cnt == RD_L) begin
                nxt_state = RD_HD;
                nxt_cnt   = '0;
            end
            RD_HD: if (cnt == HD_L) begin
                nxt_cnt = '0;
                if (last_bit) begin
                    nxt_state = DONE;
                end else begin
                    nxt_state = RD_SU;
                    nxt_idx   = idx + 1'b1;
                end
            end
            PG_CHK: begin
                nxt_cnt = '0;
                if (wdata[idx]) begin
                    nxt_state = PG_SU;
                end else if (last_bit) begin
                    nxt_state = DONE;
                end else begin
                    nxt_idx = idx + 1'b1;
                end
            end
            PG_SU: if (cnt == SU_L) begin
                nxt_state = PG_STB;
                nxt_cnt   = '0;
            end
            PG_STB: if (cnt == PG_L) begin
                nxt_state = PG_HD;
                nxt_cnt   = '0;
            end
            PG_HD: if (cnt == HD_L) begin
                nxt_cnt = '0;
                if (last_bit) begin
                    nxt_state = DONE;
                end else begin
                    nxt_state = PG_CHK;
                    nxt_idx   = idx + 1'b1;
                end
            end
            DONE: begin
                nxt_state = IDLE;
                nxt_cnt   = '0;
            end
            default: nxt_state = IDLE;
        endcase
    end

    // State registers and outputs registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            wdata       <= '0;
            shadow      <= '0;
            rd_mode     <= 1'b0;
            rd_done     <= 1'b0;
            wr_done     <= 1'b0;
            data_read   <= '0;
            busy        <= 1'b0;
            efuse_cs    <= 1'b0;
            efuse_addr  <= '0;
            efuse_strb  <= 1'b0;
            efuse_pgmen <= 1'b0;
            efuse_mr    <= 1'b0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            idx        <= nxt_idx;
            busy       <= (nxt_state != IDLE);
            efuse_addr <= nxt_idx;
            efuse_cs   <= (nxt_state inside {RD_SU, RD_STB, RD_HD,
                                             PG_SU, PG_STB, PG_HD});
            efuse_strb <= (nxt_state inside {RD_STB, PG_STB});
            efuse_pgmen <= (nxt_state inside {PG_SU, PG_STB, PG_HD});
            rd_done    <= (nxt_state == DONE) && rd_mode;
            wr_done    <= (nxt_state == DONE) && !rd_mode;
            if (state == IDLE && read) begin
                rd_mode  <= 1'b1;
                shadow   <= '0;
                efuse_mr <= margin_read;
            end else if (state == IDLE && write) begin
                rd_mode <= 1'b0;
                wdata   <= data_write;
            end else if (state == DONE) begin
                efuse_mr <= 1'b0;
            end
            if (state == RD_STB && cnt == RD_L)
                shadow[idx] <= efuse_dout;
            if (nxt_state == DONE && rd_mode)
                data_read <= shadow;
        end
    end

endmodule

// File: tb/tb_efuse_macro_ctrl.sv
// Bench for efuse_macro_ctrl: small-parameter instance with a fuse
// model plus a default-parameter instance for the long margin read.
module tb_efuse_macro_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Small instance: NBITS=4, T_SU=1, T_RD=2, T_PGM=3, T_HD=1
    logic       s_rst, s_read, s_write, s_mr_in;
    logic [3:0] s_wd;
    logic       s_rd_done, s_wr_done, s_busy;
    logic [3:0] s_data;
    logic       s_cs, s_strb, s_pgmen, s_mr, s_dout;
    logic [1:0] s_addr;
    logic [3:0] img = 4'b1010;

    efuse_macro_ctrl #(
        .NBITS(4), .AW(2), .T_SU(1), .T_RD(2), .T_PGM(3), .T_HD(1)
    ) u_small (
        .clk(clk), .rst(s_rst), .read(s_read), .write(s_write),
        .margin_read(s_mr_in), .data_write(s_wd),
        .rd_done(s_rd_done), .wr_done(s_wr_done), .data_read(s_data),
        .busy(s_busy), .efuse_cs(s_cs), .efuse_addr(s_addr),
        .efuse_strb(s_strb), .efuse_pgmen(s_pgmen), .efuse_mr(s_mr),
        .efuse_dout(s_dout)
    );

    assign s_dout = (s_cs && s_strb && !s_pgmen) ? img[s_addr] : 1'b0;

    always @(posedge clk)
        if (s_cs && s_pgmen && s_strb) img[s_addr] <= 1'b1;

    // Default instance
    logic        b_rst, b_read, b_write, b_mr_in;
    logic [31:0] b_wd;
    logic        b_rd_done, b_wr_done, b_busy;
    logic [31:0] b_data;
    logic        b_cs, b_strb, b_pgmen, b_mr, b_dout;
    logic [4:0]  b_addr;
    logic [31:0] bpat = 32'hC35A_96E1;

    efuse_macro_ctrl u_big (
        .clk(clk), .rst(b_rst), .read(b_read), .write(b_write),
        .margin_read(b_mr_in), .data_write(b_wd),
        .rd_done(b_rd_done), .wr_done(b_wr_done), .data_read(b_data),
        .busy(b_busy), .efuse_cs(b_cs), .efuse_addr(b_addr),
        .efuse_strb(b_strb), .efuse_pgmen(b_pgmen), .efuse_mr(b_mr),
        .efuse_dout(b_dout)
    );

    assign b_dout = (b_cs && b_strb) ? bpat[b_addr] : 1'b0;

    typedef struct {
        bit         rd;
        bit         wr;
        bit         mr;
        logic [3:0] wd;
        int         lat;
        logic [3:0] data;
        int         nstrb;
    } vec_t;

    typedef struct {
        bit         rd;
        bit         mr;
        logic [3:0] mask;
        int         lat;
        logic [3:0] data;
        int         nstrb;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.rd    = v.rd;
        e.mr    = v.mr;
        e.mask  = v.rd ? 4'hF : v.wd;
        e.lat   = v.lat;
        e.data  = v.data;
        e.nstrb = v.nstrb;
        sb.push_back(e);
    endtask

    // Called between a negedge and the accept edge of the small DUT.
    task automatic watch(input string nm, input bit hold, input bit keep_wr);
        exp_t e;
        int lat, nstrb;
        logic [3:0] smask, pmask;
        bit mr_or, mr_and, pm_mr, cs_bad, done, got_rd, got_wr;
        @(posedge clk);
        @(negedge clk);
        chk({nm, ".busy"}, 32'(s_busy), 32'd1);
        if (!hold) begin
            s_read  = 1'b0;
            s_write = 1'b0;
        end
        lat = 0; nstrb = 0; smask = '0; pmask = '0;
        mr_or = 1'b0; mr_and = 1'b1; pm_mr = 1'b0; cs_bad = 1'b0;
        done = 1'b0; got_rd = 1'b0; got_wr = 1'b0;
        while (1) begin
            if (s_strb) begin
                nstrb++;
                smask[s_addr] = 1'b1;
                if (!s_cs) cs_bad = 1'b1;
            end
            if (s_pgmen) begin
                pmask[s_addr] = 1'b1;
                if (s_mr) pm_mr = 1'b1;
            end
            mr_or  = mr_or | s_mr;
            mr_and = mr_and & s_mr;
            if (s_rd_done || s_wr_done) begin
                done   = 1'b1;
                got_rd = s_rd_done;
                got_wr = s_wr_done;
            end
            if (done || lat >= 300) break;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({nm, ".finished"}, 32'(done), 32'd1);
        if (sb.size() == 0) begin
            chk({nm, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({nm, ".latency"}, 32'(lat), 32'(e.lat));
            chk({nm, ".rd_done"}, 32'(got_rd), 32'(e.rd));
            chk({nm, ".wr_done"}, 32'(got_wr), 32'(!e.rd));
            chk({nm, ".data_read"}, 32'(s_data), 32'(e.data));
            chk({nm, ".strobes"}, 32'(nstrb), 32'(e.nstrb));
            chk({nm, ".strb_addrs"}, 32'(smask), 32'(e.mask));
            chk({nm, ".pgmen_addrs"}, 32'(pmask),
                e.rd ? 32'd0 : 32'(e.mask));
            chk({nm, ".mr"}, {30'd0, mr_or, mr_and},
                e.rd ? {30'd0, e.mr, e.mr} : 32'd0);
            chk({nm, ".pgmen_mr"}, 32'(pm_mr), 32'd0);
            chk({nm, ".strb_cs"}, 32'(cs_bad), 32'd0);
        end
        s_read = 1'b0;
        if (!keep_wr) s_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({nm, ".after"}, {28'd0, s_rd_done, s_wr_done, s_busy, s_mr},
            32'd0);
    endtask

    vec_t vt[8];

    initial begin
        int n, i_lat, i_strb;
        bit seen, wd_seen, mr_and;

        vt[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 16, 4'hA, 8};
        vt[1] = '{1'b0, 1'b1, 1'b0, 4'hA, 14, 4'hA, 6};
        vt[2] = '{1'b0, 1'b1, 1'b0, 4'h0,  4, 4'hA, 0};
        vt[3] = '{1'b0, 1'b1, 1'b0, 4'h1,  9, 4'hA, 3};
        vt[4] = '{1'b1, 1'b0, 1'b1, 4'h0, 16, 4'hB, 8};
        vt[5] = '{1'b0, 1'b1, 1'b0, 4'hC, 14, 4'hB, 6};
        vt[6] = '{1'b1, 1'b0, 1'b0, 4'h0, 16, 4'hF, 8};
        vt[7] = '{1'b0, 1'b1, 1'b0, 4'hF, 24, 4'hF, 12};

        s_rst = 1'b1; s_read = 1'b0; s_write = 1'b0;
        s_mr_in = 1'b0; s_wd = '0;
        b_rst = 1'b1; b_read = 1'b0; b_write = 1'b0;
        b_mr_in = 1'b0; b_wd = '0;
        repeat (2) @(negedge clk);
        chk("reset.small", {21'd0, s_rd_done, s_wr_done, s_data, s_busy,
            s_cs, s_addr, s_strb, s_pgmen, s_mr}, 32'd0);
        chk("reset.big", {b_rd_done, b_wr_done, b_busy, b_cs, b_addr,
            b_strb, b_pgmen, b_mr}, 32'd0);
        chk("reset.big_data", b_data, 32'd0);
        s_rst = 1'b0;
        b_rst = 1'b0;
        @(negedge clk);
        chk("idle.small", {28'd0, s_busy, s_cs, s_strb, s_pgmen}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            s_read  = vt[i].rd;
            s_write = vt[i].wr;
            s_mr_in = vt[i].mr;
            s_wd    = vt[i].wd;
            push_exp(vt[i]);
            watch($sformatf("v%0d", i), vt[i].rd, 1'b0);
        end

        // read and write together: read first, then the held write
        s_read = 1'b1; s_write = 1'b1; s_mr_in = 1'b1; s_wd = 4'b0010;
        push_exp('{1'b1, 1'b0, 1'b1, 4'h0, 16, 4'hF, 8});
        watch("both_rd", 1'b1, 1'b1);
        s_mr_in = 1'b0;
        push_exp('{1'b0, 1'b1, 1'b0, 4'b0010, 9, 4'hF, 3});
        watch("both_wr", 1'b1, 1'b0);

        // reset during a program strobe
        s_write = 1'b1; s_wd = 4'b0001;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (s_strb && s_pgmen) seen = 1'b1;
        end
        chk("rst.pgm_strobe_seen", 32'(seen), 32'd1);
        s_write = 1'b0;
        s_rst = 1'b1;
        #1;
        chk("rst.async_drop", {29'd0, s_strb, s_pgmen, s_busy}, 32'd0);
        wd_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            wd_seen = wd_seen | s_wr_done;
        end
        chk("rst.no_wr_done", 32'(wd_seen), 32'd0);
        chk("rst.data_read", 32'(s_data), 32'd0);
        s_rst = 1'b0;
        @(negedge clk);
        s_read = 1'b1;
        push_exp('{1'b1, 1'b0, 1'b0, 4'h0, 16, 4'hF, 8});
        watch("post_rst", 1'b1, 1'b0);

        // default parameters: margin read with margin_read toggling
        b_read = 1'b1; b_mr_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_lat = 0; i_strb = 0; mr_and = 1'b1; seen = 1'b0;
        while (1) begin
            mr_and = mr_and & b_mr;
            if (b_strb) i_strb++;
            if (b_rd_done) seen = 1'b1;
            if (seen || i_lat >= 400) break;
            b_mr_in = ~b_mr_in;
            @(posedge clk);
            i_lat++;
            @(negedge clk);
        end
        chk("big.finished", 32'(seen), 32'd1);
        chk("big.latency", 32'(i_lat), 32'd224);
        chk("big.data_read", b_data, 32'hC35A_96E1);
        chk("big.mr_held", 32'(mr_and), 32'd1);
        chk("big.strobes", 32'(i_strb), 32'd128);
        chk("big.no_pgmen", 32'(b_pgmen | b_wr_done), 32'd0);
        b_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("big.after", {29'd0, b_mr, b_busy, b_rd_done}, 32'd0);
        n = sb.size();
        chk("sb.drained", 32'(n), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
